pc_fetch_unit: RTL

Sequential instruction-fetch front end that owns the program counter for the LEGv8 datapath. It issues a request to instruction memory at CurrentPC, captures the returned word, and presents it to decode with a valid/ready handshake. It closes the loop with the next-PC computation: on instruction acceptance it loads the NextPC value supplied by the branch/next-PC logic and starts the next fetch.

---
 rtl/pc_fetch_unit_pkg.sv | 26 ++
 rtl/pc_fetch_unit_timeout.sv | 41 ++++
 rtl/pc_fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch front end.
package pc_fetch_unit_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 64;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        ISSUE = 2'b10,
        FAULT = 2'b11
    } fetch_state_e;

    typedef logic [1:0] fault_code_t;

    localparam fault_code_t FC_NONE     = 2'b00;
    localparam fault_code_t FC_MISALIGN = 2'b01;
    localparam fault_code_t FC_TIMEOUT  = 2'b10;

    // LEGv8 instructions are word aligned
    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_timeout.sv
// Counts REQ cycles without an acknowledge; flags the cycle whose miss
// would bring the count up to TIMEOUT. TIMEOUT=0 disables the flag.
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Count value during the last permitted waiting cycle
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on REQ entry, advance on each unacknowledged REQ cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one instruction-memory
// request at a time and hands the returned word to decode via valid/ready.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Enable,
    output logic        IMemReq,
    output logic [63:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic        InstValid,
    input  logic        InstReady,
    input  logic [63:0] NextPC,
    output logic [63:0] CurrentPC,
    output logic [31:0] RetireCount,
    output logic        Fault,
    output logic [1:0]  FaultCode
);

    fetch_state_e        state_q,  state_d;
    logic [ADDR_W-1:0]   pc_q,     pc_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic                req_q,    req_d;
    logic [INST_W-1:0]   inst_q,   inst_d;
    logic                valid_q,  valid_d;
    logic [31:0]         retire_q, retire_d;
    logic                fault_q,  fault_d;
    fault_code_t         fcode_q,  fcode_d;

    logic tmo_clear;
    logic tmo_en;
    logic tmo_expired;

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (CLK),
        .rst_i     (Reset),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_en),
        .expired_o (tmo_expired)
    );

    // Fetch sequencer next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        inst_d    = inst_q;
        valid_d   = valid_q;
        retire_d  = retire_q;
        fault_d   = fault_q;
        fcode_d   = fcode_q;
        tmo_clear = 1'b0;
        tmo_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (Enable) begin
                    req_d     = 1'b1;
                    addr_d    = pc_q;
                    tmo_clear = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // An ack in the expiring cycle takes priority over the timeout
                if (IMemAck) begin
                    inst_d  = IMemData;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ISSUE;
                end else if (tmo_expired) begin
                    fault_d = 1'b1;
                    fcode_d = FC_TIMEOUT;
                    req_d   = 1'b0;
                    state_d = FAULT;
                end else begin
                    tmo_en = 1'b1;
                end
            end
            ISSUE: begin
                if (InstReady) begin
                    valid_d = 1'b0;
                    if (!is_aligned(NextPC)) begin
                        fault_d = 1'b1;
                        fcode_d = FC_MISALIGN;
                        state_d = FAULT;
                    end else begin
                        pc_d     = NextPC;
                        retire_d = retire_q + 32'd1;
                        if (Enable) begin
                            req_d     = 1'b1;
                            addr_d    = NextPC;
                            tmo_clear = 1'b1;
                            state_d   = REQ;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            FAULT: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            req_q    <= 1'b0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            retire_q <= '0;
            fault_q  <= 1'b0;
            fcode_q  <= FC_NONE;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            retire_q <= retire_d;
            fault_q  <= fault_d;
            fcode_q  <= fcode_d;
        end
    end

    assign IMemReq     = req_q;
    assign IMemAddr    = addr_q;
    assign Instruction = inst_q;
    assign InstValid   = valid_q;
    assign CurrentPC   = pc_q;
    assign RetireCount = retire_q;
    assign Fault       = fault_q;
    assign FaultCode   = fcode_q;

endmodule
